// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control-unit to datapath bundle
// Carries the opcode/flag/handshake inputs and every datapath strobe, status and counter.
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             RegWrite;
  logic             ALUSrcA;
  logic             IorD;
  logic             IRWrite;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             RegDst;
  logic             MemtoReg;
  logic             MemR;
  logic             MemWrite;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic             pc_en;
  logic             halted;
  logic [3:0]       state;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, zero, mem_ready,
    output RegWrite, ALUSrcA, IorD, IRWrite, PCWrite, PCWriteCond, RegDst,
           MemtoReg, MemR, MemWrite, ALUSrcB, ALUOp, PCSource, pc_en, halted,
           state, cycle_count, instr_retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  RegWrite, ALUSrcA, IorD, IRWrite, PCWrite, PCWriteCond, RegDst,
           MemtoReg, MemR, MemWrite, ALUSrcB, ALUOp, PCSource, pc_en, halted,
           state, cycle_count, instr_retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RISC-V main control FSM
// Strobes are registered from the next state; only the mem_ready/zero gating is combinational.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXR    = 4'd7,
    S_EXI    = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_TRAP   = 4'd15
  } state_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src_a;
    logic       ior_d;
    logic       mem_r;
    logic       mem_write;
    logic       pc_write_cond;
    logic       mem_to_reg;
    logic       fetch;
    logic       halted;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             counting;
  logic             retire;
  logic             pc_write;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_r = 1'b1; c.fetch = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_r = 1'b1; c.ior_d = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
      S_EXR:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_EXI:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      S_ALUWB:  c.reg_write = 1'b1;
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_TRAP:   c.halted = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LD, OP_SD: state_d = S_MEMADR;
          OP_R:         state_d = S_EXR;
          OP_I:         state_d = S_EXI;
          OP_BR:        state_d = S_BRANCH;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SD) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_EXR, S_EXI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase

    ctrl_d = decode(state_d);

    // Counters stop in RESET and TRAP; a store retires only on the cycle memory accepts it.
    counting  = (state_q != S_RESET) && (state_q != S_TRAP);
    retire    = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                ((state_q == S_MEMWR) && bus.mem_ready);
    cycle_d   = counting ? cycle_q + CNT_ONE : cycle_q;
    retired_d = retire ? retired_q + CNT_ONE : retired_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RESET;
      ctrl_q    <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
    end
  end

  assign pc_write          = ctrl_q.fetch & bus.mem_ready;
  assign bus.RegWrite      = ctrl_q.reg_write;
  assign bus.ALUSrcA       = ctrl_q.alu_src_a;
  assign bus.IorD          = ctrl_q.ior_d;
  assign bus.IRWrite       = pc_write;
  assign bus.PCWrite       = pc_write;
  assign bus.PCWriteCond   = ctrl_q.pc_write_cond;
  assign bus.RegDst        = 1'b0;
  assign bus.MemtoReg      = ctrl_q.mem_to_reg;
  assign bus.MemR          = ctrl_q.mem_r;
  assign bus.MemWrite      = ctrl_q.mem_write;
  assign bus.ALUSrcB       = ctrl_q.alu_src_b;
  assign bus.ALUOp         = ctrl_q.alu_op;
  assign bus.PCSource      = ctrl_q.pc_source;
  assign bus.pc_en         = pc_write | (ctrl_q.pc_write_cond & bus.zero);
  assign bus.halted        = ctrl_q.halted;
  assign bus.state         = state_q;
  assign bus.cycle_count   = cycle_q;
  assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed vector bench for multicycle_control_fsm
// Strobe word order: RegWrite ALUSrcA IorD IRWrite PCWrite PCWriteCond RegDst MemtoReg MemR MemWrite ALUSrcB ALUOp PCSource.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(32)) bus ();
  multicycle_control_fsm_if #(.CNT_W(4))  bus4 ();

  multicycle_control_fsm #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  multicycle_control_fsm #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  localparam logic [15:0] W_ZERO     = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] W_FETCH    = 16'b0_0_0_1_1_0_0_0_1_0_01_00_00;
  localparam logic [15:0] W_FETCH_ST = 16'b0_0_0_0_0_0_0_0_1_0_01_00_00;
  localparam logic [15:0] W_DECODE   = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] W_MEMADR   = 16'b0_1_0_0_0_0_0_0_0_0_10_00_00;
  localparam logic [15:0] W_MEMRD    = 16'b0_0_1_0_0_0_0_0_1_0_00_00_00;
  localparam logic [15:0] W_MEMWB    = 16'b1_0_0_0_0_0_0_1_0_0_00_00_00;
  localparam logic [15:0] W_MEMWR    = 16'b0_0_1_0_0_0_0_0_0_1_00_00_00;
  localparam logic [15:0] W_EXR      = 16'b0_1_0_0_0_0_0_0_0_0_00_10_00;
  localparam logic [15:0] W_EXI      = 16'b0_1_0_0_0_0_0_0_0_0_10_11_00;
  localparam logic [15:0] W_ALUWB    = 16'b1_0_0_0_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] W_BRANCH   = 16'b0_1_0_0_0_1_0_0_0_0_00_01_01;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  wire [15:0] ctrl_w = {bus.RegWrite, bus.ALUSrcA, bus.IorD, bus.IRWrite, bus.PCWrite,
                        bus.PCWriteCond, bus.RegDst, bus.MemtoReg, bus.MemR, bus.MemWrite,
                        bus.ALUSrcB, bus.ALUOp, bus.PCSource};

  typedef struct {
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctrl;
    logic        exp_pc_en;
    logic        exp_halted;
    int          exp_retired;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[32];
  int passed = 0;
  int total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] st, input logic [15:0] ctrl,
                               input logic pc_en, input logic halted, input int ret, input int cyc);
    check({tag, " state"}, 32'(bus.state), 32'(st));
    check({tag, " strobes"}, 32'(ctrl_w), 32'(ctrl));
    check({tag, " pc_en"}, 32'(bus.pc_en), 32'(pc_en));
    check({tag, " halted"}, 32'(bus.halted), 32'(halted));
    check({tag, " retired"}, bus.instr_retired, ret);
    check({tag, " cycles"}, bus.cycle_count, cyc);
  endtask

  initial begin
    // add, addi, sd (fetch stall + store stall), beq taken/not, ld with 3 stalls, illegal
    vecs[0]  = '{RT,  1'b0, 1'b1, 4'd0,  W_ZERO,     1'b0, 1'b0, 0, 0};
    vecs[1]  = '{RT,  1'b0, 1'b1, 4'd1,  W_FETCH,    1'b1, 1'b0, 0, 0};
    vecs[2]  = '{RT,  1'b1, 1'b1, 4'd2,  W_DECODE,   1'b0, 1'b0, 0, 1};
    vecs[3]  = '{RT,  1'b1, 1'b1, 4'd7,  W_EXR,      1'b0, 1'b0, 0, 2};
    vecs[4]  = '{RT,  1'b0, 1'b1, 4'd9,  W_ALUWB,    1'b0, 1'b0, 0, 3};
    vecs[5]  = '{IT,  1'b0, 1'b1, 4'd1,  W_FETCH,    1'b1, 1'b0, 1, 4};
    vecs[6]  = '{IT,  1'b0, 1'b1, 4'd2,  W_DECODE,   1'b0, 1'b0, 1, 5};
    vecs[7]  = '{IT,  1'b0, 1'b1, 4'd8,  W_EXI,      1'b0, 1'b0, 1, 6};
    vecs[8]  = '{IT,  1'b0, 1'b1, 4'd9,  W_ALUWB,    1'b0, 1'b0, 1, 7};
    vecs[9]  = '{SD,  1'b0, 1'b0, 4'd1,  W_FETCH_ST, 1'b0, 1'b0, 2, 8};
    vecs[10] = '{SD,  1'b0, 1'b1, 4'd1,  W_FETCH,    1'b1, 1'b0, 2, 9};
    vecs[11] = '{SD,  1'b0, 1'b1, 4'd2,  W_DECODE,   1'b0, 1'b0, 2, 10};
    vecs[12] = '{SD,  1'b0, 1'b1, 4'd3,  W_MEMADR,   1'b0, 1'b0, 2, 11};
    vecs[13] = '{SD,  1'b0, 1'b0, 4'd6,  W_MEMWR,    1'b0, 1'b0, 2, 12};
    vecs[14] = '{SD,  1'b0, 1'b1, 4'd6,  W_MEMWR,    1'b0, 1'b0, 2, 13};
    vecs[15] = '{BR,  1'b0, 1'b1, 4'd1,  W_FETCH,    1'b1, 1'b0, 3, 14};
    vecs[16] = '{BR,  1'b0, 1'b1, 4'd2,  W_DECODE,   1'b0, 1'b0, 3, 15};
    vecs[17] = '{BR,  1'b1, 1'b1, 4'd10, W_BRANCH,   1'b1, 1'b0, 3, 16};
    vecs[18] = '{BR,  1'b0, 1'b1, 4'd1,  W_FETCH,    1'b1, 1'b0, 4, 17};
    vecs[19] = '{BR,  1'b0, 1'b1, 4'd2,  W_DECODE,   1'b0, 1'b0, 4, 18};
    vecs[20] = '{BR,  1'b0, 1'b1, 4'd10, W_BRANCH,   1'b0, 1'b0, 4, 19};
    vecs[21] = '{LD,  1'b0, 1'b1, 4'd1,  W_FETCH,    1'b1, 1'b0, 5, 20};
    vecs[22] = '{LD,  1'b0, 1'b1, 4'd2,  W_DECODE,   1'b0, 1'b0, 5, 21};
    vecs[23] = '{LD,  1'b0, 1'b1, 4'd3,  W_MEMADR,   1'b0, 1'b0, 5, 22};
    vecs[24] = '{LD,  1'b0, 1'b0, 4'd4,  W_MEMRD,    1'b0, 1'b0, 5, 23};
    vecs[25] = '{LD,  1'b0, 1'b0, 4'd4,  W_MEMRD,    1'b0, 1'b0, 5, 24};
    vecs[26] = '{LD,  1'b0, 1'b0, 4'd4,  W_MEMRD,    1'b0, 1'b0, 5, 25};
    vecs[27] = '{LD,  1'b0, 1'b1, 4'd4,  W_MEMRD,    1'b0, 1'b0, 5, 26};
    vecs[28] = '{LD,  1'b0, 1'b1, 4'd5,  W_MEMWB,    1'b0, 1'b0, 5, 27};
    vecs[29] = '{BAD, 1'b0, 1'b1, 4'd1,  W_FETCH,    1'b1, 1'b0, 6, 28};
    vecs[30] = '{BAD, 1'b0, 1'b1, 4'd2,  W_DECODE,   1'b0, 1'b0, 6, 29};
    vecs[31] = '{BAD, 1'b1, 1'b1, 4'd15, W_ZERO,     1'b0, 1'b1, 6, 30};

    bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    bus4.opcode = RT; bus4.zero = 1'b0; bus4.mem_ready = 1'b1;

    @(negedge clk);
    check_outputs("reset", 4'd0, W_ZERO, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      bus.opcode = vecs[i].opcode;
      bus.zero = vecs[i].zero;
      bus.mem_ready = vecs[i].mem_ready;
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].exp_state, vecs[i].exp_ctrl,
                    vecs[i].exp_pc_en, vecs[i].exp_halted, vecs[i].exp_retired, vecs[i].exp_cycles);
      @(negedge clk);
    end

    // TRAP holds with counters frozen regardless of inputs
    for (int i = 0; i < 10; i++) begin
      bus.opcode = RT; bus.mem_ready = 1'b1; bus.zero = i[0];
      #1;
      check_outputs($sformatf("trap%0d", i), 4'd15, W_ZERO, 1'b0, 1'b1, 6, 30);
      @(negedge clk);
    end

    rst = 1'b1;
    #1;
    check_outputs("trap_rst", 4'd0, W_ZERO, 1'b0, 1'b0, 0, 0);

    // reset asserted asynchronously in the middle of EXR
    @(negedge clk);
    rst = 1'b0;
    bus.opcode = RT; bus.zero = 1'b1; bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mid_exr pre state", 32'(bus.state), 32'd7);
    #1;
    rst = 1'b1;
    #1;
    check_outputs("mid_exr rst", 4'd0, W_ZERO, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release state", 32'(bus.state), 32'd0);
    @(negedge clk);
    #1;
    check("fetch after release", 32'(bus.state), 32'd1);

    // 4-bit counters: 16 back-to-back R-type instructions wrap both to zero
    @(negedge clk);
    rst4 = 1'b0;
    repeat (61) @(posedge clk);
    @(negedge clk);
    check("wrap retired 15", 32'(bus4.instr_retired), 32'd15);
    check("wrap cycles 60", 32'(bus4.cycle_count), 32'd12);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("wrap state", 32'(bus4.state), 32'd1);
    check("wrap retired", 32'(bus4.instr_retired), 32'd0);
    check("wrap cycles", 32'(bus4.cycle_count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
